// File: rtl/counter_sequencer.sv
// Sequencer for the N-bit up/down counter: load low bound, ramp up to high, ramp down to low,
// repeated for num_cycles rounds at a prescaled rate, with pause and stop.
module counter_sequencer #(
  parameter int N = 32,
  parameter int C = 8,
  parameter int P = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic [N-1:0] low_value,
  input  logic [N-1:0] high_value,
  input  logic [C-1:0] num_cycles,
  input  logic [P-1:0] tick_div,
  input  logic [N-1:0] counter_value,
  output logic         cnt_enable,
  output logic         cnt_dec,
  output logic         cnt_load,
  output logic [N-1:0] cnt_load_value,
  output logic         busy,
  output logic         done,
  output logic         phase_up,
  output logic [C-1:0] cycle_count,
  output logic         error
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t       r_state;
  logic [P-1:0] r_prescale;
  logic [C-1:0] r_cycle_count;

  logic [P-1:0] w_div_m1;
  logic         w_counting;
  logic         w_tick;
  logic         w_at_high;
  logic         w_at_low;
  logic         w_bounds_ok;
  logic [C-1:0] w_cycle_next;
  logic         w_last_round;

  // tick_div of 0 behaves as 1; >= keeps the prescaler bounded if tick_div drops mid-count
  assign w_div_m1     = (tick_div == {P{1'b0}}) ? {P{1'b0}} : (tick_div - {{(P-1){1'b0}}, 1'b1});
  assign w_counting   = ((r_state == S_UP) || (r_state == S_DOWN)) && !pause && !stop;
  assign w_tick       = w_counting && (r_prescale >= w_div_m1);
  assign w_at_high    = (counter_value >= high_value);
  assign w_at_low     = (counter_value <= low_value);
  assign w_bounds_ok  = (high_value > low_value);
  assign w_cycle_next = (&r_cycle_count) ? r_cycle_count
                                         : (r_cycle_count + {{(C-1){1'b0}}, 1'b1});
  assign w_last_round = (num_cycles != {C{1'b0}}) && (w_cycle_next == num_cycles);
  assign cycle_count  = r_cycle_count;

  // Control outputs decoded from state, tick and the counter read-back
  always_comb begin
    cnt_enable     = 1'b0;
    cnt_dec        = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_value = high_value;
    busy           = 1'b0;
    done           = 1'b0;
    phase_up       = 1'b0;
    error          = 1'b0;
    case (r_state)
      S_IDLE: begin
        cnt_load_value = reset ? high_value : {N{1'b0}};
        error          = reset && start && !stop && !w_bounds_ok;
      end
      S_LOAD: begin
        cnt_load       = !stop;
        cnt_load_value = low_value;
        busy           = 1'b1;
      end
      S_UP: begin
        busy       = 1'b1;
        phase_up   = 1'b1;
        cnt_enable = w_tick && !w_at_high;
      end
      S_DOWN: begin
        busy       = 1'b1;
        cnt_dec    = 1'b1;
        cnt_enable = w_tick && !w_at_low;
      end
      S_DONE: begin
        done = !stop;
      end
      default: begin
        cnt_enable = 1'b0;
      end
    endcase
  end

  // State, prescaler and round counter; stop outranks every other input outside IDLE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_prescale    <= {P{1'b0}};
      r_cycle_count <= {C{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !stop && w_bounds_ok) begin
            r_cycle_count <= {C{1'b0}};
            r_state       <= S_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (stop) begin
            r_state <= S_IDLE;
          end else begin
            r_prescale <= {P{1'b0}};
            r_state    <= S_UP;
          end
        end
        S_UP: begin
          if (stop) begin
            r_state <= S_IDLE;
          end else if (pause) begin
            r_state <= S_UP;
          end else if (w_at_high) begin
            r_prescale <= {P{1'b0}};
            r_state    <= S_DOWN;
          end else if (w_tick) begin
            r_prescale <= {P{1'b0}};
          end else begin
            r_prescale <= r_prescale + {{(P-1){1'b0}}, 1'b1};
          end
        end
        S_DOWN: begin
          if (stop) begin
            r_state <= S_IDLE;
          end else if (pause) begin
            r_state <= S_DOWN;
          end else if (w_at_low) begin
            r_prescale    <= {P{1'b0}};
            r_cycle_count <= w_cycle_next;
            r_state       <= w_last_round ? S_DONE : S_UP;
          end else if (w_tick) begin
            r_prescale <= {P{1'b0}};
          end else begin
            r_prescale <= r_prescale + {{(P-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench: sequencer driving a behavioural up/down counter, expected values hand-computed.
module tb_counter_sequencer;
  localparam int N = 32;
  localparam int C = 8;
  localparam int P = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         pause = 1'b0;
  logic [N-1:0] low_value = 32'd2;
  logic [N-1:0] high_value = 32'd5;
  logic [C-1:0] num_cycles = 8'd2;
  logic [P-1:0] tick_div = 16'd1;
  logic [N-1:0] counter_value;
  logic         cnt_enable, cnt_dec, cnt_load, busy, done, phase_up, error;
  logic [N-1:0] cnt_load_value;
  logic [C-1:0] cycle_count;

  int n_checks = 0;
  int n_pass = 0;
  int overlap = 0;
  int en_cnt;
  int done_cnt;
  int exp_t1 [8] = '{2, 3, 4, 5, 5, 4, 3, 2};

  counter_sequencer #(.N(N), .C(C), .P(P)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .low_value(low_value), .high_value(high_value), .num_cycles(num_cycles),
    .tick_div(tick_div), .counter_value(counter_value), .cnt_enable(cnt_enable),
    .cnt_dec(cnt_dec), .cnt_load(cnt_load), .cnt_load_value(cnt_load_value),
    .busy(busy), .done(done), .phase_up(phase_up), .cycle_count(cycle_count),
    .error(error)
  );

  always #5 clock = ~clock;

  // Stand-in for the team's up/down counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) counter_value <= '0;
    else if (cnt_load) counter_value <= cnt_load_value;
    else if (cnt_enable) counter_value <= cnt_dec ? counter_value - 1 : counter_value + 1;
  end

  always @(negedge clock) if (cnt_load && cnt_enable) overlap++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    #1 reset = 1'b0;
    #2;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_enable", 32'(cnt_enable), 0);
    check_eq("rst_load", 32'(cnt_load), 0);
    check_eq("rst_load_value", cnt_load_value, 0);
    check_eq("rst_cycle_count", 32'(cycle_count), 0);
    check_eq("rst_done", 32'(done), 0);
    cyc(); cyc();
    reset = 1'b1;
    cyc();

    // 1: basic two-round run, tick_div=1
    start_pulse();
    check_eq("t1_load", 32'(cnt_load), 1);
    check_eq("t1_load_value", cnt_load_value, 2);
    check_eq("t1_load_noen", 32'(cnt_enable), 0);
    for (int k = 1; k <= 18; k++) begin
      cyc();
      if (k <= 8) check_eq($sformatf("t1_cv_k%0d", k), counter_value, exp_t1[k-1]);
      if (k == 4) check_eq("t1_phase_up", 32'(phase_up), 1);
      if (k == 5) check_eq("t1_dec", 32'(cnt_dec), 1);
      if (k == 9) check_eq("t1_cc1", 32'(cycle_count), 1);
      if (k == 16) check_eq("t1_done_early", 32'(done), 0);
      if (k == 17) check_eq("t1_done", 32'(done), 1);
      if (k == 17) check_eq("t1_cc2", 32'(cycle_count), 2);
      if (k == 18) check_eq("t1_busy_end", 32'(busy), 0);
      if (k == 18) check_eq("t1_done_end", 32'(done), 0);
    end

    // 2: tick_div=3, one step every 3 clocks
    tick_div = 16'd3;
    cyc(); cyc();
    start_pulse();
    en_cnt = 0;
    for (int k = 1; k <= 41; k++) begin
      cyc();
      if (cnt_enable) en_cnt++;
      if (k == 3) check_eq("t2_cv_k3", counter_value, 2);
      if (k == 4) check_eq("t2_cv_k4", counter_value, 3);
      if (k == 40) check_eq("t2_done_early", 32'(done), 0);
      if (k == 41) check_eq("t2_done", 32'(done), 1);
    end
    check_eq("t2_enable_count", en_cnt, 12);

    // 3: pause 10 cycles at counter_value=4 in UP
    tick_div = 16'd1;
    cyc(); cyc();
    start_pulse();
    for (int k = 1; k <= 28; k++) begin
      cyc();
      pause = (k >= 3 && k <= 12);
      #1;
      if (k == 3) check_eq("t3_cv_pause", counter_value, 4);
      if (k == 3) check_eq("t3_en_pause", 32'(cnt_enable), 0);
      if (k == 8) check_eq("t3_cv_hold", counter_value, 4);
      if (k == 8) check_eq("t3_busy_hold", 32'(busy), 1);
      if (k == 13) check_eq("t3_en_resume", 32'(cnt_enable), 1);
      if (k == 14) check_eq("t3_cv_resume", counter_value, 5);
      if (k == 26) check_eq("t3_done_early", 32'(done), 0);
      if (k == 27) check_eq("t3_done", 32'(done), 1);
    end
    pause = 1'b0;

    // 4: stop in second round DOWN at counter_value=3
    cyc(); cyc();
    start_pulse();
    for (int k = 1; k <= 15; k++) cyc();
    check_eq("t4_cv", counter_value, 3);
    check_eq("t4_phase", 32'(phase_up), 0);
    check_eq("t4_cc", 32'(cycle_count), 1);
    stop = 1'b1;
    #1;
    check_eq("t4_stop_noen", 32'(cnt_enable), 0);
    cyc();
    stop = 1'b0;
    check_eq("t4_busy", 32'(busy), 0);
    check_eq("t4_cc_kept", 32'(cycle_count), 1);
    done_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (done) done_cnt++;
    end
    check_eq("t4_no_done", done_cnt, 0);
    check_eq("t4_cv_frozen", counter_value, 3);

    // 5: invalid bounds, then start+stop together
    low_value = 32'd7;
    high_value = 32'd7;
    start = 1'b1;
    #1;
    check_eq("t5_error", 32'(error), 1);
    check_eq("t5_noload", 32'(cnt_load), 0);
    cyc();
    start = 1'b0;
    #1;
    check_eq("t5_error_end", 32'(error), 0);
    check_eq("t5_busy", 32'(busy), 0);
    check_eq("t5_noload2", 32'(cnt_load), 0);
    low_value = 32'd2;
    high_value = 32'd5;
    start = 1'b1;
    stop = 1'b1;
    #1;
    check_eq("t5_ss_error", 32'(error), 0);
    cyc();
    start = 1'b0;
    stop = 1'b0;
    check_eq("t5_ss_busy", 32'(busy), 0);
    check_eq("t5_ss_noload", 32'(cnt_load), 0);

    // 6: async reset mid-UP, then free-running rounds until stop
    num_cycles = 8'd0;
    cyc();
    start_pulse();
    cyc(); cyc();
    #2 reset = 1'b0;
    #1;
    check_eq("t6_rst_busy", 32'(busy), 0);
    check_eq("t6_rst_en", 32'(cnt_enable), 0);
    check_eq("t6_rst_phase", 32'(phase_up), 0);
    check_eq("t6_rst_lv", cnt_load_value, 0);
    check_eq("t6_rst_cc", 32'(cycle_count), 0);
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    start_pulse();
    for (int k = 1; k <= 26; k++) begin
      cyc();
      if (k == 8) check_eq("t6_cc_k8", 32'(cycle_count), 0);
      if (k == 9) check_eq("t6_cc_k9", 32'(cycle_count), 1);
      if (k == 17) check_eq("t6_cc_k17", 32'(cycle_count), 2);
      if (k == 25) check_eq("t6_cc_k25", 32'(cycle_count), 3);
      if (k == 26) check_eq("t6_busy_k26", 32'(busy), 1);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check_eq("t6_stop_busy", 32'(busy), 0);
    check_eq("t6_stop_cc", 32'(cycle_count), 3);

    check_eq("load_enable_overlap", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
